// File: rtl/cgb_mode_controller_pkg.sv
// Shared console definitions for the CGB mode controller:
// FSM states, register selects and the default speed-switch stall length.
package cgb_mode_controller_pkg;

    typedef enum logic [1:0] {
        NORMAL = 2'd0,
        SWITCH = 2'd1,
        STOP   = 2'd2
    } mode_state_t;

    localparam logic [1:0] SEL_KEY0 = 2'd0;
    localparam logic [1:0] SEL_KEY1 = 2'd1;
    localparam logic [1:0] SEL_BOOT = 2'd2;

    localparam int SWITCH_CYCLES_DEF = 2050;

endpackage

// File: rtl/cgb_mode_controller.sv
// CGB mode controller: KEY0 compat latch, KEY1 speed switch, FF50 boot-ROM
// disable, and the STOP / speed-switch sequencing FSM.
module cgb_mode_controller
    import cgb_mode_controller_pkg::*;
#(
    parameter int SWITCH_CYCLES = SWITCH_CYCLES_DEF,
    parameter int CNT_W         = $clog2(SWITCH_CYCLES)
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       cpu_en,
    input  logic [1:0] reg_select,
    output logic [7:0] rdata,
    input  logic [7:0] wdata,
    input  logic       write,
    input  logic       stop_exec,
    input  logic       wake,
    output logic       cgb,
    output logic       double_speed,
    output logic       boot_rom_en,
    output logic       cpu_stall,
    output logic       div_reset,
    output logic       stop_mode
);

    mode_state_t      state_q, state_d;
    logic [CNT_W-1:0] counter_q, counter_d;
    logic             key0_compat_q, key0_compat_d;
    logic             armed_q, armed_d;
    logic             double_speed_q, double_speed_d;
    logic             boot_rom_en_q, boot_rom_en_d;
    logic             cpu_stall_q, cpu_stall_d;
    logic             stop_mode_q, stop_mode_d;

    logic stop_tick;
    logic go_switch;
    logic toggle;
    logic wr_en;
    logic unused_wdata;

    assign unused_wdata = ^{wdata[7:3], wdata[1]};

    function automatic logic [7:0] read_mux(
        input logic [1:0] sel,
        input logic       boot,
        input logic       compat,
        input logic       cgb_on,
        input logic       ds,
        input logic       arm
    );
        logic [7:0] r;
        r = 8'hff;
        if (sel == SEL_KEY0 && boot)
            r = {5'b11111, compat, 2'b11};
        else if (sel == SEL_KEY1 && cgb_on)
            r = {ds, 6'b111111, arm};
        return r;
    endfunction

    assign cgb          = ~key0_compat_q;
    assign double_speed = double_speed_q;
    assign boot_rom_en  = boot_rom_en_q;
    assign cpu_stall    = cpu_stall_q;
    assign stop_mode    = stop_mode_q;
    assign wr_en        = cpu_en & write;

    assign stop_tick = ~reset & cpu_en & stop_exec & (state_q == NORMAL);
    assign go_switch = stop_tick & cgb & armed_q;

    assign rdata = read_mux(reg_select, boot_rom_en_q, key0_compat_q,
                            cgb, double_speed_q, armed_q);

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= NORMAL;
            counter_q <= '0;
        end else begin
            state_q   <= state_d;
            counter_q <= counter_d;
        end
    end

    // Next state
    always_comb begin
        state_d   = state_q;
        counter_d = counter_q;
        toggle    = 1'b0;
        unique case (state_q)
            NORMAL: begin
                if (go_switch) begin
                    state_d   = SWITCH;
                    counter_d = CNT_W'(SWITCH_CYCLES - 1);
                end else if (stop_tick) begin
                    state_d = STOP;
                end
            end
            SWITCH: begin
                if (cpu_en) begin
                    if (counter_q == '0) begin
                        state_d = NORMAL;
                        toggle  = 1'b1;
                    end else begin
                        counter_d = counter_q - CNT_W'(1);
                    end
                end
            end
            STOP: begin
                if (cpu_en && wake)
                    state_d = NORMAL;
            end
            default: state_d = NORMAL;
        endcase
    end

    // Outputs: stall/stop are registered decodes of the next state
    always_comb begin
        cpu_stall_d = (state_d != NORMAL);
        stop_mode_d = (state_d == STOP);
        div_reset   = stop_tick;
    end

    // Register bank; a KEY1 write in the STOP tick still lands
    always_comb begin
        key0_compat_d  = key0_compat_q;
        armed_d        = armed_q;
        boot_rom_en_d  = boot_rom_en_q;
        double_speed_d = double_speed_q ^ toggle;
        if (go_switch)
            armed_d = 1'b0;
        if (wr_en) begin
            unique case (reg_select)
                SEL_KEY0: if (boot_rom_en_q) key0_compat_d = wdata[2];
                SEL_KEY1: if (cgb && state_q == NORMAL) armed_d = wdata[0];
                SEL_BOOT: if (wdata[0]) boot_rom_en_d = 1'b0;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            key0_compat_q  <= 1'b0;
            armed_q        <= 1'b0;
            boot_rom_en_q  <= 1'b1;
            double_speed_q <= 1'b0;
            cpu_stall_q    <= 1'b0;
            stop_mode_q    <= 1'b0;
        end else begin
            key0_compat_q  <= key0_compat_d;
            armed_q        <= armed_d;
            boot_rom_en_q  <= boot_rom_en_d;
            double_speed_q <= double_speed_d;
            cpu_stall_q    <= cpu_stall_d;
            stop_mode_q    <= stop_mode_d;
        end
    end

endmodule

// File: tb/tb_cgb_mode_controller.sv
// Bench for cgb_mode_controller: behavioural model compared every cycle,
// plus directed sequences with literal expectations.
module tb_cgb_mode_controller;

    localparam int SW = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic       cpu_en;
    logic [1:0] reg_select;
    logic [7:0] rdata;
    logic [7:0] wdata;
    logic       write;
    logic       stop_exec;
    logic       wake;
    logic       cgb;
    logic       double_speed;
    logic       boot_rom_en;
    logic       cpu_stall;
    logic       div_reset;
    logic       stop_mode;

    int checks = 0;
    int errors = 0;
    bit cmp_on = 0;
    int stall_cnt = 0;
    int div_cnt = 0;

    cgb_mode_controller #(.SWITCH_CYCLES(SW)) dut (
        .clk(clk), .reset(reset), .cpu_en(cpu_en),
        .reg_select(reg_select), .rdata(rdata), .wdata(wdata),
        .write(write), .stop_exec(stop_exec), .wake(wake),
        .cgb(cgb), .double_speed(double_speed),
        .boot_rom_en(boot_rom_en), .cpu_stall(cpu_stall),
        .div_reset(div_reset), .stop_mode(stop_mode)
    );

    always #5 clk = ~clk;

    // Model: 0 running, 1 switching (m_left ticks to go), 2 stopped
    int m_mode = 0;
    int m_left = 0;
    bit m_compat = 0, m_armed = 0, m_ds = 0, m_boot = 1;
    bit pre_cgb, pre_boot;
    int pre_mode;

    always @(posedge clk) begin
        if (reset) begin
            m_mode = 0; m_left = 0;
            m_compat = 0; m_armed = 0; m_ds = 0; m_boot = 1;
        end else if (cpu_en) begin
            pre_cgb  = !m_compat;
            pre_mode = m_mode;
            pre_boot = m_boot;
            if (m_mode == 0) begin
                if (stop_exec && pre_cgb && m_armed) begin
                    m_mode = 1; m_left = SW; m_armed = 0;
                end else if (stop_exec) begin
                    m_mode = 2;
                end
            end else if (m_mode == 1) begin
                m_left = m_left - 1;
                if (m_left == 0) begin
                    m_ds = !m_ds; m_mode = 0;
                end
            end else if (wake) begin
                m_mode = 0;
            end
            if (write) begin
                if (reg_select == 0 && pre_boot) m_compat = wdata[2];
                if (reg_select == 1 && pre_cgb && pre_mode == 0) m_armed = wdata[0];
                if (reg_select == 2 && wdata[0]) m_boot = 0;
            end
        end
    end

    function automatic logic [7:0] exp_rd(input logic [1:0] s);
        if (s == 2'd0) return m_boot ? {5'b11111, m_compat, 2'b11} : 8'hff;
        if (s == 2'd1) return !m_compat ? {m_ds, 6'b111111, m_armed} : 8'hff;
        return 8'hff;
    endfunction

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (cpu_stall) stall_cnt++;
        if (div_reset) div_cnt++;
        if (cmp_on) begin
            chk("m_cgb", {7'd0, cgb}, {7'd0, !m_compat});
            chk("m_ds", {7'd0, double_speed}, {7'd0, m_ds});
            chk("m_boot", {7'd0, boot_rom_en}, {7'd0, m_boot});
            chk("m_stall", {7'd0, cpu_stall}, {7'd0, m_mode != 0});
            chk("m_stop", {7'd0, stop_mode}, {7'd0, m_mode == 2});
            chk("m_div", {7'd0, div_reset},
                {7'd0, !reset && cpu_en && stop_exec && m_mode == 0});
            chk("m_rdata", rdata, exp_rd(reg_select));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic en, input logic [1:0] sel, input logic [7:0] wd,
                         input logic wr, input logic se, input logic wk);
        cpu_en = en; reg_select = sel; wdata = wd;
        write = wr; stop_exec = se; wake = wk;
    endtask

    task automatic rd(input string nm, input logic [1:0] sel, input logic [7:0] exp);
        reg_select = sel;
        #1;
        chk(nm, rdata, exp);
    endtask

    initial begin
        reset = 1'b1;
        drive(1, 0, 8'h00, 0, 0, 0);
        step();
        cmp_on = 1;
        step();
        reset = 1'b0;

        rd("rst_key0", 2'd0, 8'hfb);
        rd("rst_key1", 2'd1, 8'h7e);
        rd("rst_ff50", 2'd2, 8'hff);
        chk("rst_flags", {5'd0, cgb, boot_rom_en, double_speed}, 8'h06);

        // Armed speed switch, cpu_en every cycle
        drive(1, 1, 8'h01, 1, 0, 0); step();
        stall_cnt = 0; div_cnt = 0;
        drive(1, 1, 8'h00, 0, 1, 0); step();
        drive(1, 1, 8'h00, 0, 0, 0);
        repeat (10) step();
        chk("sw_stall", 8'(stall_cnt), 8'd4);
        chk("sw_div", 8'(div_cnt), 8'd1);
        chk("sw_ds", {7'd0, double_speed}, 8'd1);
        rd("sw_key1", 2'd1, 8'hfe);

        // Unarmed STOP, wake after 10 cycles
        stall_cnt = 0;
        drive(1, 0, 8'h00, 0, 1, 0); step();
        drive(1, 0, 8'h00, 0, 0, 0);
        repeat (5) step();
        drive(1, 0, 8'h00, 0, 1, 0); step();
        drive(1, 0, 8'h00, 0, 0, 0);
        repeat (4) step();
        chk("stop_mode", {6'd0, stop_mode, cpu_stall}, 8'h03);
        drive(1, 0, 8'h00, 0, 0, 1); step();
        drive(1, 0, 8'h00, 0, 0, 0);
        chk("wake_drop", {6'd0, stop_mode, cpu_stall}, 8'h00);
        chk("stop_len", 8'(stall_cnt), 8'd11);
        chk("stop_ds", {7'd0, double_speed}, 8'd1);

        // Speed switch with cpu_en 1-in-3
        drive(1, 1, 8'h01, 1, 0, 0); step();
        stall_cnt = 0;
        drive(1, 1, 8'h00, 0, 1, 0); step();
        for (int i = 0; i < 30; i++) begin
            drive(i % 3 == 2, 1, 8'h00, 0, 0, 0);
            step();
        end
        chk("slow_stall", 8'(stall_cnt), 8'd12);
        chk("slow_ds", {7'd0, double_speed}, 8'd0);

        // Reset two ticks into a switch
        drive(1, 1, 8'h01, 1, 0, 0); step();
        drive(1, 1, 8'h00, 0, 1, 0); step();
        drive(1, 1, 8'h00, 0, 0, 0);
        repeat (2) step();
        reset = 1'b1; step();
        chk("mid_rst", {2'd0, cgb, double_speed, boot_rom_en,
                        cpu_stall, div_reset, stop_mode}, 8'h28);
        reset = 1'b0;
        repeat (6) step();
        chk("mid_rst_ds", {6'd0, double_speed, cpu_stall}, 8'h00);

        // KEY1 write with STOP, wake already high: 1-tick STOP
        stall_cnt = 0;
        drive(1, 1, 8'h01, 1, 1, 1); step();
        drive(1, 1, 8'h00, 0, 0, 1); step();
        drive(1, 1, 8'h00, 0, 0, 0);
        repeat (2) step();
        chk("wake_len", 8'(stall_cnt), 8'd1);
        rd("same_tick_key1", 2'd1, 8'h7f);
        drive(1, 1, 8'h00, 1, 0, 0); step();

        // Compat mode locks after boot ROM disable
        drive(1, 0, 8'h04, 1, 0, 0); step();
        drive(1, 2, 8'h01, 1, 0, 0); step();
        drive(1, 0, 8'h00, 1, 0, 0); step();
        drive(1, 0, 8'h00, 0, 0, 0); step();
        chk("compat", {6'd0, cgb, boot_rom_en}, 8'h00);
        rd("cmp_key0", 2'd0, 8'hff);
        rd("cmp_key1", 2'd1, 8'hff);
        rd("cmp_sel3", 2'd3, 8'hff);
        drive(1, 1, 8'h01, 1, 0, 0); step();
        drive(1, 1, 8'h00, 0, 1, 0); step();
        drive(1, 1, 8'h00, 0, 0, 0); step();
        chk("cmp_stop", {6'd0, stop_mode, cpu_stall}, 8'h03);
        drive(1, 1, 8'h00, 0, 0, 1); step();
        drive(1, 1, 8'h00, 0, 0, 0); step();
        chk("cmp_end", {5'd0, stop_mode, cpu_stall, double_speed}, 8'h00);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cgb_mode_controller.md
Name: cgb_mode_controller

Overview:
- Owns CGB mode configuration and sequencing: KEY0 (FF4C) compatibility latch, KEY1 (FF4D) speed-switch register and the FF50 boot-ROM disable latch.
- Drives the `cgb` qualifier consumed by the CGB-only register banks, the `double_speed` select, and CPU stall/STOP control.
- Sits in the console I/O block beside the other register banks.
- Sequences the STOP-triggered speed switch and low-power STOP through a small FSM.

Parameters:
- SWITCH_CYCLES, 2050, cpu_en ticks the CPU is stalled during a speed switch (must be ≥ 2).
- CNT_W, $clog2(SWITCH_CYCLES), switch counter width.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- cpu_en  in  1  CPU-rate clock enable; all state advances only when cpu_en=1
- reg_select  in  2  0=KEY0, 1=KEY1, 2=FF50, 3=unused
- rdata  out  8  read data (combinational)
- wdata  in  8  write data
- write  in  1  register write strobe
- stop_exec  in  1  CPU executed STOP (one cpu_en tick)
- wake  in  1  joypad wake request (level)
- cgb  out  1  1 = CGB features enabled
- double_speed  out  1  current speed
- boot_rom_en  out  1  boot ROM mapped
- cpu_stall  out  1  hold CPU
- div_reset  out  1  one-tick pulse clearing DIV
- stop_mode  out  1  low-power STOP active

Behaviour:
- Reset values: key0_compat=0 (cgb=1), armed=0, double_speed=0, boot_rom_en=1, state=NORMAL, counter=0, cpu_stall=0, div_reset=0, stop_mode=0.
- Writes take effect when cpu_en & write, on the next clk edge.

KEY0:
- Writable only while boot_rom_en=1; key0_compat <= wdata[2].
- cgb = ~key0_compat (combinational from the register).
- Read: {5'b11111, key0_compat, 2'b11} while boot_rom_en=1, else 8'hff.

KEY1:
- Read: {double_speed, 6'b111111, armed} when cgb=1, else 8'hff.
- Write: armed <= wdata[0], only when cgb=1 and state=NORMAL.
- Bit 7 is read-only.

FF50:
- Write with wdata[0]=1 clears boot_rom_en. Once cleared it stays 0 until reset.
- Read: 8'hff. reg_select=3 reads 8'hff, writes ignored.

FSM states: NORMAL, SWITCH, STOP.
- NORMAL + cpu_en & stop_exec & cgb & armed → SWITCH:
  - counter <= SWITCH_CYCLES-1
  - armed <= 0
  - div_reset=1 for exactly that one cpu_en tick
- NORMAL + cpu_en & stop_exec otherwise → STOP:
  - div_reset pulse as above
- SWITCH: cpu_stall=1.
  - Each cpu_en tick: counter decrements.
  - At the tick where counter==0: double_speed toggles and state → NORMAL in the same edge.
  - Total stall = SWITCH_CYCLES ticks.
- STOP: cpu_stall=1, stop_mode=1.
  - cpu_en & wake → NORMAL. No speed change.
- cpu_stall and stop_mode are registered state decodes: asserted the cycle after entry, deasserted the cycle after exit.

Simultaneous events and boundaries:
- KEY1 write in the same tick as stop_exec: the transition uses the pre-write armed value; the write lands.
- stop_exec while not NORMAL: ignored.
- wake already high on STOP entry: exit on the next cpu_en tick, giving a 1-tick STOP.
- FF50 write in the same tick as a KEY0 write: the KEY0 write succeeds, because boot_rom_en is still 1.
- cpu_en=0: nothing changes, counter holds, div_reset stays 0.
- Reset mid-SWITCH or mid-STOP: immediate return to reset values; double_speed=0 regardless of progress.

Decomposition:
- Shared console package:
  - mode_state_t enum {NORMAL, SWITCH, STOP}
  - register-select constants SEL_KEY0, SEL_KEY1, SEL_BOOT
  - default SWITCH_CYCLES constant
- No sub-module needed.
- Optional: register read mux as a local function; counter inline.

Test Plan:
- Reset, read sel0/1/2 → 8'hfb, 8'h7e, 8'hff. cgb=1, boot_rom_en=1, double_speed=0.
- Write KEY0=8'h04, then FF50=8'h01, then KEY0=8'h00 → cgb stays 0. KEY0 and KEY1 read 8'hff. A KEY1 write of 8'h01 leaves armed=0.
- Write KEY1=8'h01, pulse stop_exec, SWITCH_CYCLES=4 with cpu_en every cycle:
  - div_reset for 1 cycle
  - cpu_stall high exactly 4 cycles
  - double_speed=1 afterwards
  - KEY1 reads 8'hfe
- stop_exec with armed=0 → stop_mode=1 and cpu_stall=1 until wake. Assert wake after 10 cycles → both drop the cycle after the wake tick; double_speed unchanged.
- cpu_en at 1-in-3 during SWITCH → counter only decrements on enabled cycles; stall spans 3×SWITCH_CYCLES clocks.
- Assert reset 2 ticks into SWITCH → next cycle all outputs at reset values; no toggle occurs.
